rob_dispatch_alloc: RTL and testbench
=====================================

Name: rob_dispatch_alloc

Overview:
- Dispatch-side allocator for the single-issue reorder buffer.
- Accepts decoded instructions from decode over a valid/ready handshake and assigns each the next free ROB entry in program order.
- Drives the ROB dispatch write port (dp/addr/pc/dstvalid/dst).
- Reclaims entries as the ROB commits, using the per-cycle commit pulse. It is the producer end of the ROB dispatch interface and the consumer of the ROB commit indication.

Parameters:
ROB_NUM, 64, number of ROB entries (power of two)
ROB_SEL, 6, log2(ROB_NUM), entry index width
INSN_LEN, 32, PC width
REG_SEL, 5, logical register index width

Ports:
clk_i  in  1  clock, all state on rising edge
reset_n_i  in  1  asynchronous active-low reset
dec_valid_i  in  1  decode offers an instruction
dec_ready_o  out  1  allocator can accept this cycle
dec_pc_i  in  INSN_LEN  instruction PC
dec_dstvalid_i  in  1  instruction writes a destination register
dec_dst_i  in  REG_SEL  destination logical register
commit_i  in  1  ROB retired its head entry this cycle
flush_i  in  1  discard all uncommitted entries
dp_o  out  1  dispatch write strobe to ROB
dp_addr_o  out  ROB_SEL  ROB entry being written
pc_dp_o  out  INSN_LEN  PC for that entry
dstvalid_dp_o  out  1  dst-valid for that entry
dst_dp_o  out  REG_SEL  dst for that entry
head_ptr_o  out  ROB_SEL  allocator's copy of the commit pointer
free_cnt_o  out  ROB_SEL+1  free entries, 0..ROB_NUM
full_o  out  1  no free entries
empty_o  out  1  no allocated entries
err_o  out  1  sticky: commit_i seen while empty

Behaviour:
- State: tail (ROB_SEL), head (ROB_SEL), count (ROB_SEL+1, allocated entries), registered dispatch output stage, err flag.
- Reset (async, reset_n_i low): tail=0, head=0, count=0, dp_o=0, dp_addr_o=0, pc_dp_o=0, dstvalid_dp_o=0, dst_dp_o=0, err_o=0. Hence free_cnt_o=ROB_NUM, full_o=0, empty_o=1, dec_ready_o=1. Reset mid-stream drops any pending dispatch immediately.
- dec_ready_o = (count != ROB_NUM) & ~flush_i. It is combinational from registered state plus flush_i, and does not depend on dec_valid_i or commit_i.
- accept = dec_valid_i & dec_ready_o.
- Latency 1: if accept in cycle N, then in cycle N+1 dp_o=1, dp_addr_o=tail(N), and pc/dstvalid/dst are the values captured at N. dp_o=0 in any cycle following a non-accept cycle. Data outputs hold their last value when dp_o=0.
- On accept: tail <= tail+1, with modulo ROB_NUM wrap (ROB_NUM-1 -> 0).
- On commit_i with count>0: head <= head+1 (wrap), freeing one entry.
- count next = count + accept - (commit_i & count!=0). Simultaneous accept and commit leaves count unchanged while both pointers advance.
- Full: count==ROB_NUM, so dec_ready_o=0 and no accept. A commit in that cycle makes dec_ready_o=1 in the next cycle.
- Empty: commit_i with count==0 does not change head or count, and sets err_o=1. err_o clears only on reset.
- Flush (flush_i=1):
  - No accept that cycle.
  - If commit_i is also asserted, head advances first.
  - Then tail <= new head and count <= 0.
  - dp_o is forced to 0 in the next cycle, even if the prior cycle's dispatch is still pending.
  - From the cycle after flush, allocation resumes at the new head.
- free_cnt_o = ROB_NUM - count. full_o = (count==ROB_NUM). empty_o = (count==0). head_ptr_o = head. All are registered-state derived.
- Invariant: (tail - head) mod ROB_NUM == count mod ROB_NUM.

Test Plan:
- Reset then dec_valid_i=1 for 3 cycles with PCs 0x100/0x104/0x108 -> dp_o high cycles 2..4, dp_addr_o 0,1,2 with the matching PCs; free_cnt_o=61.
- Fill 64 entries with no commits -> full_o=1, dec_ready_o=0, and a 65th dec_valid_i is held off. One commit_i -> next cycle dec_ready_o=1; the next allocation gets dp_addr_o=0 (wrap) and head_ptr_o=1.
- With count=10, drive dec_valid_i and commit_i together for 5 cycles -> count stays 10, head and tail each +5, dp_o every cycle.
- commit_i at reset (empty) -> err_o=1 and stays 1; head_ptr_o=0, free_cnt_o=64.
- Allocate 8 entries, commit 3, then pulse flush_i with commit_i=1 -> head=4, tail=4, count=0, no dp_o next cycle; the next accept gets dp_addr_o=4.
- Drive reset_n_i low asynchronously while dp_o=1 mid-stream -> dp_o, pointers and count go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/rob_dispatch_alloc.sv
// rob_dispatch_alloc: allocates ROB entries in program order for decoded instructions and reclaims them on commit.
// Ports: clk_i/reset_n_i clock and async active-low reset; dec_* decode valid/ready handshake with pc/dst info;
// commit_i head-retire pulse; flush_i discard uncommitted entries; dp_* registered ROB dispatch write port;
// head_ptr_o/free_cnt_o/full_o/empty_o occupancy status; err_o sticky commit-while-empty flag.
module rob_dispatch_alloc #(
  parameter int ROB_NUM  = 64,
  parameter int ROB_SEL  = 6,
  parameter int INSN_LEN = 32,
  parameter int REG_SEL  = 5
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                dec_valid_i,
  output logic                dec_ready_o,
  input  logic [INSN_LEN-1:0] dec_pc_i,
  input  logic                dec_dstvalid_i,
  input  logic [REG_SEL-1:0]  dec_dst_i,
  input  logic                commit_i,
  input  logic                flush_i,
  output logic                dp_o,
  output logic [ROB_SEL-1:0]  dp_addr_o,
  output logic [INSN_LEN-1:0] pc_dp_o,
  output logic                dstvalid_dp_o,
  output logic [REG_SEL-1:0]  dst_dp_o,
  output logic [ROB_SEL-1:0]  head_ptr_o,
  output logic [ROB_SEL:0]    free_cnt_o,
  output logic                full_o,
  output logic                empty_o,
  output logic                err_o
);
  localparam logic [ROB_SEL:0] NUM = (ROB_SEL+1)'(ROB_NUM);
  logic [ROB_SEL-1:0] tail_q, tail_d, head_q, head_d;
  logic [ROB_SEL:0]   cnt_q, cnt_d;
  logic               accept, do_commit;
  assign dec_ready_o = (cnt_q != NUM) & ~flush_i;
  assign accept      = dec_valid_i & dec_ready_o;
  assign do_commit   = commit_i & (cnt_q != '0);
  // a flush rewinds tail to the head as it stands after any same-cycle commit
  assign head_d = do_commit ? head_q + 1'b1 : head_q;
  assign tail_d = flush_i ? head_d : accept ? tail_q + 1'b1 : tail_q;
  assign cnt_d  = flush_i ? '0 : cnt_q + (ROB_SEL+1)'(accept) - (ROB_SEL+1)'(do_commit);
  assign head_ptr_o = head_q;
  assign free_cnt_o = NUM - cnt_q;
  assign full_o     = cnt_q == NUM;
  assign empty_o    = cnt_q == '0;
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tail_q        <= '0;
      head_q        <= '0;
      cnt_q         <= '0;
      dp_o          <= 1'b0;
      dp_addr_o     <= '0;
      pc_dp_o       <= '0;
      dstvalid_dp_o <= 1'b0;
      dst_dp_o      <= '0;
      err_o         <= 1'b0;
    end else begin
      tail_q <= tail_d;
      head_q <= head_d;
      cnt_q  <= cnt_d;
      dp_o   <= accept;
      err_o  <= err_o | (commit_i & (cnt_q == '0));
      if (accept) begin
        dp_addr_o     <= tail_q;
        pc_dp_o       <= dec_pc_i;
        dstvalid_dp_o <= dec_dstvalid_i;
        dst_dp_o      <= dec_dst_i;
      end
    end
  end
endmodule

// File: tb/tb_rob_dispatch_alloc.sv
// tb_rob_dispatch_alloc: directed and random checks of rob_dispatch_alloc against a queue-based reference model.
module tb_rob_dispatch_alloc;
  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        dec_valid_i = 1'b0, dec_ready_o;
  logic [31:0] dec_pc_i = '0;
  logic        dec_dstvalid_i = 1'b0;
  logic [4:0]  dec_dst_i = '0;
  logic        commit_i = 1'b0, flush_i = 1'b0;
  logic        dp_o, dstvalid_dp_o, full_o, empty_o, err_o;
  logic [5:0]  dp_addr_o, head_ptr_o;
  logic [31:0] pc_dp_o;
  logic [4:0]  dst_dp_o;
  logic [6:0]  free_cnt_o;
  int errors = 0, checks = 0;
  int q[$];
  int head_m = 0, tail_m = 0, addr_m = 0;
  bit err_m = 0, dp_m = 0, dv_m = 0;
  logic [31:0] pc_m = '0;
  logic [4:0]  dst_m = '0;
  rob_dispatch_alloc dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_pc_i(dec_pc_i), .dec_dstvalid_i(dec_dstvalid_i), .dec_dst_i(dec_dst_i),
    .commit_i(commit_i), .flush_i(flush_i), .dp_o(dp_o), .dp_addr_o(dp_addr_o),
    .pc_dp_o(pc_dp_o), .dstvalid_dp_o(dstvalid_dp_o), .dst_dp_o(dst_dp_o),
    .head_ptr_o(head_ptr_o), .free_cnt_o(free_cnt_o), .full_o(full_o), .empty_o(empty_o), .err_o(err_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_state();
    check("dp", 64'(dp_o), 64'(dp_m));
    check("dp_addr", 64'(dp_addr_o), 64'(addr_m));
    check("pc_dp", 64'(pc_dp_o), 64'(pc_m));
    check("dstvalid_dp", 64'(dstvalid_dp_o), 64'(dv_m));
    check("dst_dp", 64'(dst_dp_o), 64'(dst_m));
    check("head", 64'(head_ptr_o), 64'(head_m));
    check("free_cnt", 64'(free_cnt_o), 64'(64 - q.size()));
    check("full", 64'(full_o), 64'(q.size() == 64));
    check("empty", 64'(empty_o), 64'(q.size() == 0));
    check("err", 64'(err_o), 64'(err_m));
  endtask
  task automatic model_reset();
    q.delete();
    head_m = 0; tail_m = 0; addr_m = 0;
    err_m = 0; dp_m = 0; dv_m = 0; pc_m = '0; dst_m = '0;
  endtask
  task automatic do_reset();
    reset_n_i = 1'b0;
    dec_valid_i = 1'b0; commit_i = 1'b0; flush_i = 1'b0;
    model_reset();
    #1;
    check_state();
    check("rst_ready", 64'(dec_ready_o), 64'd1);
    @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask
  // one clock: drive at negedge, check ready combinationally, advance model at the edge, check after it
  task automatic step(input bit v, input logic [31:0] pc, input bit dv, input logic [4:0] d, input bit c, input bit f);
    bit rdy, acc;
    dec_valid_i = v; dec_pc_i = pc; dec_dstvalid_i = dv; dec_dst_i = d; commit_i = c; flush_i = f;
    rdy = (q.size() != 64) && !f;
    acc = v && rdy;
    #1;
    check("ready", 64'(dec_ready_o), 64'(rdy));
    @(posedge clk_i);
    dp_m = acc;
    if (acc) begin addr_m = tail_m; pc_m = pc; dv_m = dv; dst_m = d; end
    if (c) begin
      if (q.size() == 0) err_m = 1;
      else begin void'(q.pop_front()); head_m = (head_m + 1) % 64; end
    end
    if (f) begin q.delete(); tail_m = head_m; end
    else if (acc) begin q.push_back(tail_m); tail_m = (tail_m + 1) % 64; end
    #1;
    check_state();
    @(negedge clk_i);
  endtask
  task automatic alloc(input int n);
    for (int i = 0; i < n; i++) step(1, 32'($urandom), 1'($urandom), 5'($urandom), 0, 0);
  endtask
  initial begin
    @(negedge clk_i);
    do_reset();
    step(1, 32'h100, 1, 5'd3, 0, 0);
    step(1, 32'h104, 0, 5'd7, 0, 0);
    step(1, 32'h108, 1, 5'd9, 0, 0);
    check("free_after3", 64'(free_cnt_o), 64'd61);
    step(0, 0, 0, 0, 0, 0);
    do_reset();
    alloc(64);
    check("full_after64", 64'(full_o), 64'd1);
    step(1, 32'h200, 1, 5'd1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 32'h204, 1, 5'd2, 0, 0);
    check("wrap_addr", 64'(dp_addr_o), 64'd0);
    check("wrap_head", 64'(head_ptr_o), 64'd1);
    do_reset();
    alloc(10);
    for (int i = 0; i < 5; i++) step(1, 32'($urandom), 1, 5'($urandom), 1, 0);
    check("steady_free", 64'(free_cnt_o), 64'd54);
    do_reset();
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    check("err_sticky", 64'(err_o), 64'd1);
    do_reset();
    alloc(8);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
    step(1, 32'h300, 1, 5'd4, 1, 1);
    check("flush_head", 64'(head_ptr_o), 64'd4);
    step(1, 32'h304, 1, 5'd5, 0, 0);
    check("post_flush_addr", 64'(dp_addr_o), 64'd4);
    do_reset();
    alloc(3);
    step(1, 32'h400, 1, 5'd6, 0, 0);
    #2;
    reset_n_i = 1'b0;
    #1;
    check("async_dp", 64'(dp_o), 64'd0);
    check("async_head", 64'(head_ptr_o), 64'd0);
    check("async_free", 64'(free_cnt_o), 64'd64);
    check("async_addr", 64'(dp_addr_o), 64'd0);
    @(negedge clk_i);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int phase;
      phase = (i / 300) % 3;
      step($urandom_range(99) < (phase == 1 ? 95 : 70), 32'($urandom), 1'($urandom), 5'($urandom),
           $urandom_range(99) < (phase == 1 ? 15 : 45), $urandom_range(99) < 3);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
